// File: rtl/avalon_sink.sv
// Streaming sink: DEPTH-beat circular buffer fed by a valid/ready handshake, plus a
// 4,5,6 frame checker on accepted beats. Define AVALON_SINK_BACKPRESSURE_EN to stall every 4th cycle.
module avalon_sink #(
  parameter int DEPTH = 4,
  parameter int DW    = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     valid,
  input  logic [DW-1:0]            data,
  output logic                     ready,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [DW-1:0]            out_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     frame_done,
  output logic                     err,
  output logic [7:0]               frame_count,
  output logic [7:0]               err_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {EXP4, EXP5, EXP6} state_t;

  logic [DEPTH-1:0][DW-1:0] mem;
  logic [AW-1:0]            wr_ptr, rd_ptr;
  logic                     full, push, pop;
  state_t                   state, state_nxt;
  logic                     done_d, err_d;

  assign full = (level == FULL_LVL);

`ifdef AVALON_SINK_BACKPRESSURE_EN
  logic [1:0] bp_cnt;
  always_ff @(posedge clk) begin
    if (reset) bp_cnt <= 2'd0;
    else       bp_cnt <= bp_cnt + 2'd1;
  end
  assign ready = !full && (bp_cnt != 2'd3);
`else
  assign ready = !full;
`endif

  // ready is derived from the pre-edge level, so a pop never opens a slot the same cycle
  assign push      = valid && ready;
  assign out_valid = (level != '0);
  assign pop       = out_valid && out_ready;
  assign out_data  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= EXP4;
    else       state <= state_nxt;
  end

  // A stray 4 always restarts the frame as its first beat
  always_comb begin
    state_nxt = state;
    done_d    = 1'b0;
    err_d     = 1'b0;
    if (push) begin
      case (state)
        EXP4: begin
          if (data == DW'(4)) state_nxt = EXP5;
          else                err_d     = 1'b1;
        end
        EXP5: begin
          if (data == DW'(5)) state_nxt = EXP6;
          else begin
            err_d     = 1'b1;
            state_nxt = (data == DW'(4)) ? EXP5 : EXP4;
          end
        end
        EXP6: begin
          if (data == DW'(6)) begin
            done_d    = 1'b1;
            state_nxt = EXP4;
          end else begin
            err_d     = 1'b1;
            state_nxt = (data == DW'(4)) ? EXP5 : EXP4;
          end
        end
        default: state_nxt = EXP4;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_done  <= 1'b0;
      err         <= 1'b0;
      frame_count <= 8'd0;
      err_count   <= 8'd0;
    end else begin
      frame_done <= done_d;
      err        <= err_d;
      if (done_d) frame_count <= frame_count + 8'd1;
      if (err_d && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end
endmodule

// File: doc/avalon_sink.md
AVALON_SINK -- requirements
Module: avalon_sink

Interface
REQ-001 SHALL have parameter DEPTH, default 4, buffer depth in beats (power of two, >=2).
REQ-002 SHALL have parameter DW, default 8, data width.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port valid  input  1  upstream beat valid.
REQ-006 SHALL have port data  input  DW  upstream beat payload.
REQ-007 SHALL have port ready  output  1  sink can accept a beat this cycle.
REQ-008 SHALL have port out_ready  input  1  local consumer pops a buffered beat.
REQ-009 SHALL have port out_valid  output  1  buffer non-empty.
REQ-010 SHALL have port out_data  output  DW  oldest buffered beat.
REQ-011 SHALL have port level  output  $clog2(DEPTH)+1  current buffer occupancy.
REQ-012 SHALL have port frame_done  output  1  one-cycle pulse on completed 4,5,6 frame.
REQ-013 SHALL have port err  output  1  one-cycle pulse on sequence mismatch.
REQ-014 SHALL have port frame_count  output  8  completed frames, wraps 255->0.
REQ-015 SHALL have port err_count  output  8  mismatches, saturates at 255.

Function
REQ-016 Transfer SHALL occur on a rising edge where valid=1 and ready=1; no other beat is accepted.
REQ-017 ready SHALL be combinational: ready = (level != DEPTH), subject to REQ-030.
REQ-018 Accepted beat SHALL be written to a circular buffer; wr pointer wraps DEPTH-1 -> 0.
REQ-019 out_valid SHALL equal (level != 0); out_data SHALL show the head entry with zero latency.
REQ-020 Pop SHALL occur on an edge where out_valid=1 and out_ready=1; rd pointer wraps DEPTH-1 -> 0.
REQ-021 Simultaneous push and pop SHALL leave level unchanged; out_ready while empty SHALL be ignored.
REQ-022 When full, ready SHALL be 0 even if a pop occurs in the same cycle (no pass-through).
REQ-023 Checker FSM states: EXP4, EXP5, EXP6; advances only on accepted beats, not on pops.
REQ-024 EXP4: data==4 -> EXP5; else err pulse, stay EXP4.
REQ-025 EXP5: data==5 -> EXP6; data==4 -> err pulse, EXP5; else err pulse, EXP4.
REQ-026 EXP6: data==6 -> frame_done pulse, frame_count+1, EXP4; data==4 -> err pulse, EXP5; else err pulse, EXP4.
REQ-027 frame_done and err SHALL be registered, asserted the cycle after the accepting edge, width exactly one cycle.
REQ-028 err_count SHALL increment with each err pulse, holding at 255.

Reset
REQ-029 On reset=1 at an edge: pointers, level, frame_count, err_count = 0; FSM = EXP4; frame_done=err=0; out_valid=0; ready=1 next cycle; buffer contents discarded; reset mid-frame SHALL discard partial frame without err.

Configuration
REQ-030 Macro AVALON_SINK_BACKPRESSURE_EN: when defined, a free-running 2-bit counter (reset to 0) SHALL force ready=0 whenever counter==3 (every 4th cycle), in addition to full; when undefined, ready depends only on full.

Verification
REQ-031 Reset, then beats 4,5,6 with valid=1, out_ready=1 -> frame_done pulse once, frame_count=1, err_count=0, out_data sequence 4,5,6.
REQ-032 out_ready=0, push 5 beats 4,5,6,4,5 -> ready=0 after 4th accept, level=4, 5th beat held until a pop, then accepted.
REQ-033 Beats 4,5,4,5,6 -> one err pulse at second 4, frame_done once, err_count=1, frame_count=1.
REQ-034 Beats 7,4,5,6 then reset after 4,5 of next frame -> err_count=1 then 0, frame_count 1 then 0, level=0, no err on reset.
REQ-035 Push and pop every cycle with level=2 for 8 cycles -> level stays 2, pointers wrap, data order preserved.
REQ-036 With AVALON_SINK_BACKPRESSURE_EN, empty buffer, valid held high -> ready low cycles 3,7,11 after reset; 3 beats accepted per 4 cycles.
